// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, op encodings,
// mstatus/mip bit positions and interrupt cause codes.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // MEIP/MTIP/MSIP (and their enables) live at bits 11, 7 and 3
  localparam logic [11:0] IRQ_MASK = 12'h888;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with a write port that takes precedence over the
// increment; used for mcycle and minstret.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     count <= '0;
    else if (we) count <= wdata;
    else if (en) count <= count + W'(1);
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: atomic RW/RS/RC, trap/MRET sequencing, counters, interrupts.
// Define CSR_VECTORED_MTVEC_EN to allow mtvec MODE=01 (vectored interrupts).
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            timer_int_i,
  input  logic            soft_int_i,
  input  logic            ext_int_i,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            int_req_o,
  output logic [XLEN-1:0] int_cause_o
);

`ifdef CSR_VECTORED_MTVEC_EN
  localparam logic [XLEN-1:0] MTVEC_INIT =
    {MTVEC_RESET[XLEN-1:2], 1'b0, (MTVEC_RESET[1:0] == 2'b01)};
`else
  localparam logic [XLEN-1:0] MTVEC_INIT = {MTVEC_RESET[XLEN-1:2], 2'b00};
`endif

  csr_op_e         op;
  logic            mie_bit, mpie_bit;
  logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [1:0]      inhibit_q;
  logic [63:0]     mcycle_q, minstret_q, cyc_wdata, ins_wdata;
  logic [XLEN-1:0] old_val, wval, mstatus_rd, inhibit_rd, pend;
  logic            implemented, read_only, wr_req, do_wr, cyc_we, ins_we;

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mpie_bit;
    mstatus_rd[MSTATUS_MIE]  = mie_bit;
    inhibit_rd = '0;
    inhibit_rd[2] = inhibit_q[1];
    inhibit_rd[0] = inhibit_q[0];
  end

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:       old_val = mstatus_rd;
      CSR_MIE:           old_val = mie_q;
      CSR_MTVEC:         old_val = mtvec_q;
      CSR_MCOUNTINHIBIT: old_val = inhibit_rd;
      CSR_MSCRATCH:      old_val = mscratch_q;
      CSR_MEPC:          old_val = mepc_q;
      CSR_MCAUSE:        old_val = mcause_q;
      CSR_MTVAL:         old_val = mtval_q;
      CSR_MIP:           old_val = mip_q;
      CSR_MCYCLE:        old_val = mcycle_q[XLEN-1:0];
      CSR_MINSTRET:      old_val = minstret_q[XLEN-1:0];
      CSR_MCYCLEH:       if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);
                         else implemented = 1'b0;
      CSR_MINSTRETH:     if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]);
                         else implemented = 1'b0;
      CSR_MHARTID: begin
        old_val   = HARTID;
        read_only = 1'b1;
      end
      default:           implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RS: wval = old_val | csr_wdata_i;
      CSR_OP_RC: wval = old_val & ~csr_wdata_i;
      default:   wval = csr_wdata_i;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal even on mhartid
  assign wr_req        = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && (|csr_wdata_i));
  assign csr_illegal_o = (op != CSR_OP_NONE) && (!implemented || (read_only && wr_req));
  assign csr_rdata_o   = old_val;
  assign do_wr         = wr_req && implemented && !read_only && !trap_i && !mret_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit    <= 1'b0;
      mpie_bit   <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_INIT;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      inhibit_q  <= '0;
    end else begin
      mip_q <= XLEN'({ext_int_i, 3'b000, timer_int_i, 3'b000, soft_int_i, 3'b000});
      if (trap_i) begin
        mepc_q   <= trap_pc_i & ~XLEN'(3);
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
      end else if (mret_i) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end else if (do_wr) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mie_bit  <= wval[MSTATUS_MIE];
            mpie_bit <= wval[MSTATUS_MPIE];
          end
          CSR_MIE:           mie_q <= wval & XLEN'(IRQ_MASK);
`ifdef CSR_VECTORED_MTVEC_EN
          CSR_MTVEC:         mtvec_q <= {wval[XLEN-1:2], 1'b0, (wval[1:0] == 2'b01)};
`else
          CSR_MTVEC:         mtvec_q <= {wval[XLEN-1:2], 2'b00};
`endif
          CSR_MCOUNTINHIBIT: inhibit_q <= {wval[2], wval[0]};
          CSR_MSCRATCH:      mscratch_q <= wval;
          CSR_MEPC:          mepc_q <= wval & ~XLEN'(3);
          CSR_MCAUSE:        mcause_q <= wval;
          CSR_MTVAL:         mtval_q <= wval;
          default: ;
        endcase
      end
    end
  end

  // With XLEN=32 the low/high CSR halves each replace only their half of the count
  assign cyc_we    = do_wr && (csr_addr_i == CSR_MCYCLE || csr_addr_i == CSR_MCYCLEH);
  assign ins_we    = do_wr && (csr_addr_i == CSR_MINSTRET || csr_addr_i == CSR_MINSTRETH);
  assign cyc_wdata = (csr_addr_i == CSR_MCYCLEH) ? {wval[31:0], mcycle_q[31:0]} :
                     (XLEN == 32) ? {mcycle_q[63:32], wval[31:0]} : 64'(wval);
  assign ins_wdata = (csr_addr_i == CSR_MINSTRETH) ? {wval[31:0], minstret_q[31:0]} :
                     (XLEN == 32) ? {minstret_q[63:32], wval[31:0]} : 64'(wval);

  csr_counter #(.W(64)) u_mcycle (
    .clk(clk), .rst(rst), .en(!inhibit_q[0]), .we(cyc_we),
    .wdata(cyc_wdata), .count(mcycle_q)
  );

  csr_counter #(.W(64)) u_minstret (
    .clk(clk), .rst(rst), .en(instret_i && !inhibit_q[1]), .we(ins_we),
    .wdata(ins_wdata), .count(minstret_q)
  );

  always_comb begin
    trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
    if (mtvec_q[0] && trap_cause_i[XLEN-1])
      trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00} + {trap_cause_i[XLEN-3:0], 2'b00};
`endif
  end

  assign mepc_o    = mepc_q;
  assign pend      = mip_q & mie_q;
  assign int_req_o = mie_bit && (pend[IRQ_MEI] || pend[IRQ_MSI] || pend[IRQ_MTI]);

  always_comb begin
    int_cause_o = '0;
    int_cause_o[XLEN-1] = 1'b1;
    if (pend[IRQ_MEI])      int_cause_o[3:0] = IRQ_MEI;
    else if (pend[IRQ_MSI]) int_cause_o[3:0] = IRQ_MSI;
    else                    int_cause_o[3:0] = IRQ_MTI;
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed-vector bench for csr_unit (XLEN=64); expectations are hand-computed.
// Honours CSR_VECTORED_MTVEC_EN for the mtvec mode expectations.
module tb_csr_unit;
  import csr_pkg::*;

  localparam int          XLEN = 64;
  localparam logic [63:0] HART = 64'd5;
  localparam logic [63:0] MTVR = 64'h1000;
  localparam logic [63:0] IRQ  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  csr_op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [63:0] csr_wdata_i = '0, trap_cause_i = '0, trap_pc_i = '0, trap_tval_i = '0;
  logic        trap_i = 0, mret_i = 0, instret_i = 0;
  logic        timer_int_i = 0, soft_int_i = 0, ext_int_i = 0;
  logic [63:0] csr_rdata_o, trap_vector_o, mepc_o, int_cause_o;
  logic        csr_illegal_o, int_req_o;

  int n_checks = 0;
  int n_fail   = 0;

  csr_unit #(.XLEN(XLEN), .HARTID(HART), .MTVEC_RESET(MTVR)) dut (
    .clk(clk), .rst(rst),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .instret_i(instret_i),
    .timer_int_i(timer_int_i), .soft_int_i(soft_int_i), .ext_int_i(ext_int_i),
    .trap_vector_o(trap_vector_o), .mepc_o(mepc_o),
    .int_req_o(int_req_o), .int_cause_o(int_cause_o)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    tick();
    csr_op_i = CSR_OP_NONE; csr_wdata_i = '0;
  endtask

  task automatic check_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_addr_i = a;
    #1;
    check_val(tag, csr_rdata_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_rd("rst_mstatus", CSR_MSTATUS, 64'h1800);
    check_rd("rst_mtvec", CSR_MTVEC, MTVR);
    check_val("rst_int_req", int_req_o, 0);
    check_val("rst_mepc", mepc_o, 0);
    check_val("rst_vector", trap_vector_o, MTVR);
    check_rd("mhartid", CSR_MHARTID, HART);

    // illegal address and read-only write
    csr_op_i = CSR_OP_RW; csr_addr_i = 12'h7C0; csr_wdata_i = 64'h1; #1;
    check_val("illegal_addr", csr_illegal_o, 1);
    check_val("illegal_rdata", csr_rdata_o, 0);
    csr_addr_i = CSR_MHARTID; #1;
    check_val("ro_write_illegal", csr_illegal_o, 1);
    csr_op_i = CSR_OP_RS; csr_wdata_i = 64'h0; #1;
    check_val("ro_rs_zero_legal", csr_illegal_o, 0);
    csr_do(CSR_OP_RW, 12'h7C0, 64'h1);
    check_rd("mhartid_kept", CSR_MHARTID, HART);

    // RS / RC on mie
    csr_op_i = CSR_OP_RS; csr_addr_i = CSR_MIE; csr_wdata_i = 64'h80; #1;
    check_val("mie_rs_legal", csr_illegal_o, 0);
    check_val("mie_old", csr_rdata_o, 0);
    tick(); csr_op_i = CSR_OP_NONE;
    check_rd("mie_rs", CSR_MIE, 64'h80);
    csr_do(CSR_OP_RC, CSR_MIE, 64'h80);
    check_rd("mie_rc", CSR_MIE, 64'h0);
    csr_op_i = CSR_OP_RS; csr_addr_i = CSR_MIE; csr_wdata_i = 64'h0; #1;
    check_val("rs_zero_legal", csr_illegal_o, 0);
    tick(); csr_op_i = CSR_OP_NONE;
    check_rd("rs_zero_nowrite", CSR_MIE, 64'h0);

    // mip writes ignored, not illegal
    csr_op_i = CSR_OP_RW; csr_addr_i = CSR_MIP; csr_wdata_i = 64'hFFF; #1;
    check_val("mip_wr_legal", csr_illegal_o, 0);
    tick(); csr_op_i = CSR_OP_NONE;
    check_rd("mip_wr_ignored", CSR_MIP, 64'h0);

    // mstatus field masking
    csr_do(CSR_OP_RW, CSR_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
    check_rd("mstatus_mask", CSR_MSTATUS, 64'h1888);

    // interrupts
    csr_do(CSR_OP_RW, CSR_MIE, 64'h80);
    timer_int_i = 1'b1; #1;
    check_val("int_latency", int_req_o, 0);
    tick();
    check_val("int_req_mti", int_req_o, 1);
    check_val("int_cause_mti", int_cause_o, IRQ | 64'd7);
    check_rd("mip_mtip", CSR_MIP, 64'h80);
    csr_do(CSR_OP_RW, CSR_MIE, 64'h888);
    soft_int_i = 1'b1; tick();
    check_val("int_cause_msi", int_cause_o, IRQ | 64'd3);
    ext_int_i = 1'b1; tick();
    check_val("int_cause_mei", int_cause_o, IRQ | 64'd11);
    csr_do(CSR_OP_RW, CSR_MSTATUS, 64'h0);
    check_val("int_gated_mie", int_req_o, 0);
    timer_int_i = 0; soft_int_i = 0; ext_int_i = 0;
    tick();

    // trap beats simultaneous MRET and CSR write
    csr_do(CSR_OP_RW, CSR_MSTATUS, 64'h8);
    check_rd("mstatus_mie", CSR_MSTATUS, 64'h1808);
    trap_i = 1; mret_i = 1;
    trap_pc_i = 64'h8000_0100; trap_cause_i = 64'd2; trap_tval_i = 64'hDEAD;
    csr_op_i = CSR_OP_RW; csr_addr_i = CSR_MEPC; csr_wdata_i = 64'h1234; #1;
    check_val("trap_vector_exc", trap_vector_o, MTVR);
    tick();
    trap_i = 0; mret_i = 0; csr_op_i = CSR_OP_NONE;
    check_val("trap_mepc", mepc_o, 64'h8000_0100);
    check_rd("trap_mcause", CSR_MCAUSE, 64'd2);
    check_rd("trap_mtval", CSR_MTVAL, 64'hDEAD);
    check_rd("trap_mstatus", CSR_MSTATUS, 64'h1880);
    mret_i = 1; tick(); mret_i = 0;
    check_rd("mret_mstatus", CSR_MSTATUS, 64'h1888);
    csr_do(CSR_OP_RW, CSR_MEPC, 64'h1237);
    check_rd("mepc_align", CSR_MEPC, 64'h1234);

    // mcycle inhibit, write-wins and wrap
    csr_do(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h7);
    check_rd("inhibit_mask", CSR_MCOUNTINHIBIT, 64'h5);
    csr_do(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h1);
    csr_do(CSR_OP_RW, CSR_MCYCLE, 64'd100);
    repeat (3) tick();
    check_rd("mcycle_frozen", CSR_MCYCLE, 64'd100);
    csr_do(CSR_OP_RW, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_do(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h0);
    check_rd("mcycle_max", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check_rd("mcycle_wrap", CSR_MCYCLE, 64'd0);
    csr_do(CSR_OP_RW, CSR_MCYCLE, 64'd50);
    check_rd("mcycle_write_wins", CSR_MCYCLE, 64'd50);
    tick();
    check_rd("mcycle_inc", CSR_MCYCLE, 64'd51);

    // minstret
    instret_i = 1; repeat (3) tick(); instret_i = 0;
    check_rd("minstret_3", CSR_MINSTRET, 64'd3);
    csr_do(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h4);
    instret_i = 1; repeat (2) tick();
    check_rd("minstret_inhibit", CSR_MINSTRET, 64'd3);
    csr_do(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h0);
    csr_do(CSR_OP_RW, CSR_MINSTRET, 64'd10);
    check_rd("minstret_write_wins", CSR_MINSTRET, 64'd10);
    tick(); instret_i = 0;
    check_rd("minstret_inc", CSR_MINSTRET, 64'd11);

    // mtvec mode
    csr_do(CSR_OP_RW, CSR_MTVEC, 64'h8000_0001);
    trap_cause_i = IRQ | 64'd7; #1;
`ifdef CSR_VECTORED_MTVEC_EN
    check_val("vector_irq7", trap_vector_o, 64'h8000_001C);
    check_rd("mtvec_mode", CSR_MTVEC, 64'h8000_0001);
`else
    check_val("vector_irq7", trap_vector_o, 64'h8000_0000);
    check_rd("mtvec_mode", CSR_MTVEC, 64'h8000_0000);
`endif
    trap_cause_i = 64'd7; #1;
    check_val("vector_exc7", trap_vector_o, 64'h8000_0000);

    // reset during an in-flight write
    csr_do(CSR_OP_RW, CSR_MSCRATCH, 64'h55);
    check_rd("mscratch", CSR_MSCRATCH, 64'h55);
    csr_op_i = CSR_OP_RW; csr_addr_i = CSR_MSCRATCH; csr_wdata_i = 64'hABC;
    #3 rst = 1'b1;
    tick();
    csr_op_i = CSR_OP_NONE;
    rst = 1'b0;
    check_rd("rst_mscratch", CSR_MSCRATCH, 64'h0);
    check_rd("rst_mstatus2", CSR_MSTATUS, 64'h1800);
    check_rd("rst_mtvec2", CSR_MTVEC, MTVR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
